// File: rtl/bias_add_lanes.sv
// -----------------------------------------------------------------------------
// bias_add_lanes
//
// Purpose
//   Multi-lane bias adder for the post-array datapath. It sits between the
//   systolic-array drain and the requantiser. Each lane of a packed signed
//   accumulator vector receives its own programmable signed bias. The sum is
//   saturated to the output width, and every lane that clipped is flagged.
//   The block is a two-stage pipeline with valid/ready handshakes on both
//   sides. It holds up to two beats and preserves their order.
//
//   Stage 1 registers the full-precision (IN_W+1)-bit sums. That width cannot
//   overflow because BIAS_W <= IN_W. Stage 2 registers the saturated results
//   and the per-lane clip flags, and it drives the outputs directly.
//
// Parameters
//   LANES   number of parallel lanes (>= 1)
//   IN_W    signed width of each input lane
//   BIAS_W  signed width of each bias register (BIAS_W <= IN_W)
//   OUT_W   signed width of each output lane (OUT_W <= IN_W+1)
//   SEL_W   derived width of the bias lane select
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-high reset
//   bias_we_i    in   bias register write strobe
//   bias_sel_i   in   lane index of the bias write (values >= LANES are ignored)
//   bias_data_i  in   signed bias value
//   valid_i      in   input beat valid
//   ready_o      out  block can accept an input beat (combinational from ready_i)
//   data_i       in   packed signed lanes, lane k = [k*IN_W +: IN_W]
//   valid_o      out  output beat valid
//   ready_i      in   downstream accepts the output beat
//   data_o       out  packed saturated sums, lane k = [k*OUT_W +: OUT_W]
//   sat_o        out  per-lane saturation flags, qualified by valid_o
// -----------------------------------------------------------------------------
module bias_add_lanes #(
    parameter  int LANES  = 4,
    parameter  int IN_W   = 32,
    parameter  int BIAS_W = 32,
    parameter  int OUT_W  = 32,
    localparam int SEL_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   bias_we_i,
    input  logic [SEL_W-1:0]       bias_sel_i,
    input  logic [BIAS_W-1:0]      bias_data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [LANES*IN_W-1:0]  data_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [LANES*OUT_W-1:0] data_o,
    output logic [LANES-1:0]       sat_o
);

    // Full-precision sum type. One bit wider than the input lane, so the
    // addition of a sign-extended lane and bias can never wrap.
    typedef logic signed [IN_W:0] sum_t;

    // Saturation limits expressed in the sum width. When OUT_W == IN_W+1
    // the limits equal the full sum range, and the clamp never fires.
    localparam sum_t SUM_ONE = sum_t'(1);
    localparam sum_t SUM_MAX = (SUM_ONE <<< (OUT_W - 1)) - SUM_ONE;
    localparam sum_t SUM_MIN = -(SUM_ONE <<< (OUT_W - 1));

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic signed [BIAS_W-1:0] r_bias [LANES];

    logic                     r_s1_v;
    sum_t                     r_s1_sum [LANES];

    logic                     r_s2_v;
    logic [LANES*OUT_W-1:0]   r_s2_data;
    logic [LANES-1:0]         r_s2_sat;

    logic                     w_s1_adv;
    logic                     w_s2_adv;
    sum_t                     w_sum [LANES];
    logic [LANES*OUT_W-1:0]   w_sat_data;
    logic [LANES-1:0]         w_sat_flag;

    // -------------------------------------------------------------------------
    // Flow control
    // -------------------------------------------------------------------------
    // A stage may load when it is empty or when its content moves on this
    // cycle. ready_o is therefore a combinational function of ready_i. This
    // is what lets a full pipe accept and retire in the same cycle.
    always_comb begin
        w_s2_adv = !r_s2_v || ready_i;
        w_s1_adv = !r_s1_v || w_s2_adv;
    end

    assign ready_o = w_s1_adv;

    // -------------------------------------------------------------------------
    // Bias register file
    // -------------------------------------------------------------------------
    // NOTE: this is a handful of flops rather than a RAM macro, so it can be
    // cleared by reset. A beat must never pick up a stale bias from before
    // reset.
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples the pre-edge values. In particular, a beat accepted on the
    // same edge as a bias write still sees the old bias.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < LANES; k++) begin
                r_bias[k] <= '0;
            end
        end else if (bias_we_i) begin
            // A full decode against every lane index. An out-of-range select
            // simply matches no lane, so the write is dropped.
            for (int k = 0; k < LANES; k++) begin
                if (bias_sel_i == SEL_W'(k)) begin
                    r_bias[k] <= bias_data_i;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: full-precision add
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any conditional
    // logic. A path that leaves a variable unassigned would otherwise infer a
    // latch.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_sum[k] = '0;
        end
        for (int k = 0; k < LANES; k++) begin
            // Casting a signed operand to the wider sum type sign-extends it.
            w_sum[k] = sum_t'($signed(data_i[k*IN_W +: IN_W])) + sum_t'(r_bias[k]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1_v <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                r_s1_sum[k] <= '0;
            end
        end else if (w_s1_adv) begin
            r_s1_v <= valid_i;
            // The data only loads with a real beat, to keep toggling down on
            // idle cycles.
            if (valid_i) begin
                r_s1_sum <= w_sum;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: saturate to OUT_W
    // -------------------------------------------------------------------------
    always_comb begin
        w_sat_data = '0;
        w_sat_flag = '0;
        for (int k = 0; k < LANES; k++) begin
            if (r_s1_sum[k] > SUM_MAX) begin
                w_sat_data[k*OUT_W +: OUT_W] = SUM_MAX[OUT_W-1:0];
                w_sat_flag[k]                = 1'b1;
            end else if (r_s1_sum[k] < SUM_MIN) begin
                w_sat_data[k*OUT_W +: OUT_W] = SUM_MIN[OUT_W-1:0];
                w_sat_flag[k]                = 1'b1;
            end else begin
                // In range, so the low OUT_W bits already form the
                // correctly signed result.
                w_sat_data[k*OUT_W +: OUT_W] = r_s1_sum[k][OUT_W-1:0];
            end
        end
    end

    // Stage 2 only advances when downstream takes the beat or the stage is
    // empty. data_o and sat_o therefore hold while valid_o && !ready_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s2_v    <= 1'b0;
            r_s2_data <= '0;
            r_s2_sat  <= '0;
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_data <= w_sat_data;
                r_s2_sat  <= w_sat_flag;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign valid_o = r_s2_v;
    assign data_o  = r_s2_data;
    assign sat_o   = r_s2_sat;

endmodule

// File: tb/tb_bias_add_lanes.sv
// -----------------------------------------------------------------------------
// tb_bias_add_lanes
//
// Two instances of bias_add_lanes are used. Instance A (LANES=4, OUT_W=32)
// runs the directed scenarios: the basic add and its latency, saturation and
// its limits, backpressure, the bias-write race, and asynchronous reset.
// Instance B (LANES=8, OUT_W=16) runs a randomized stream against a
// scoreboard. The scoreboard computes the biased, clamped sums with plain
// integer arithmetic.
// -----------------------------------------------------------------------------
module tb_bias_add_lanes;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Instance A signals
    logic         a_bias_we   = 1'b0;
    logic [1:0]   a_bias_sel  = '0;
    logic [31:0]  a_bias_data = '0;
    logic         a_valid_i   = 1'b0;
    logic         a_ready_o;
    logic [127:0] a_data_i    = '0;
    logic         a_valid_o;
    logic         a_ready_i   = 1'b0;
    logic [127:0] a_data_o;
    logic [3:0]   a_sat_o;

    // Instance B signals
    logic         b_bias_we   = 1'b0;
    logic [2:0]   b_bias_sel  = '0;
    logic [31:0]  b_bias_data = '0;
    logic         b_valid_i   = 1'b0;
    logic         b_ready_o;
    logic [255:0] b_data_i    = '0;
    logic         b_valid_o;
    logic         b_ready_i   = 1'b0;
    logic [127:0] b_data_o;
    logic [7:0]   b_sat_o;

    bias_add_lanes #(.LANES(4), .IN_W(32), .BIAS_W(32), .OUT_W(32)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .bias_we_i(a_bias_we), .bias_sel_i(a_bias_sel), .bias_data_i(a_bias_data),
        .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i),
        .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o), .sat_o(a_sat_o)
    );

    bias_add_lanes #(.LANES(8), .IN_W(32), .BIAS_W(32), .OUT_W(16)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .bias_we_i(b_bias_we), .bias_sel_i(b_bias_sel), .bias_data_i(b_bias_data),
        .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o), .sat_o(b_sat_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge. Outputs are read before the
    // next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set_bias(input int k, input logic [31:0] v);
        a_bias_we   = 1'b1;
        a_bias_sel  = 2'(k);
        a_bias_data = v;
        tick();
        a_bias_we   = 1'b0;
    endtask

    // Backpressure beat v: lane k carries v + 16*k, so lane swaps are visible.
    function automatic logic [127:0] a_beat(input int v);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'(v + 16 * k);
        return r;
    endfunction

    // Random values concentrated around the 16-bit clamp limits
    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'($urandom_range(0, 80000)) - 32'd40000;
            2:       return 32'($urandom_range(0, 200)) + 32'd32668;
            default: return 32'd0 - 32'($urandom_range(32668, 32868));
        endcase
    endfunction

    typedef struct {
        logic [127:0] d;
        logic [7:0]   s;
        int           acc;
    } exp_t;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_a_valid", a_valid_o, 1'b0);
        check("rst_a_data", a_data_o, '0);
        check("rst_a_sat", a_sat_o, '0);
        check("rst_b_valid", b_valid_o, 1'b0);
        rst = 1'b0;
        tick();

        // ---------------- 1: basic add and latency ----------------
        a_ready_i = 1'b1;
        a_set_bias(0, 32'd10);
        a_set_bias(1, -32'sd5);
        a_set_bias(2, 32'd0);
        a_set_bias(3, 32'd7);
        a_data_i  = {32'd100, 32'd100, 32'd100, 32'd100};
        a_valid_i = 1'b1;
        #1;
        check("t1_ready", a_ready_o, 1'b1);
        tick();
        a_valid_i = 1'b0;
        check("t1_valid_n1", a_valid_o, 1'b0);
        tick();
        check("t1_valid_n2", a_valid_o, 1'b1);
        check("t1_data", a_data_o, {32'd107, 32'd100, 32'd95, 32'd110});
        check("t1_sat", a_sat_o, 4'b0000);

        // ---------------- 2: saturation and exact limits ----------------
        a_set_bias(0, 32'h100);
        a_set_bias(1, -32'sd16);
        a_set_bias(3, 32'd0);
        a_data_i  = {32'h80000000, 32'h7FFFFFFF, 32'h80000001, 32'h7FFFFFF0};
        a_valid_i = 1'b1;
        tick();
        a_valid_i = 1'b0;
        tick();
        check("t2_valid", a_valid_o, 1'b1);
        check("t2_data", a_data_o, {32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF});
        check("t2_sat", a_sat_o, 4'b0011);

        // ---------------- 3: backpressure ----------------
        a_set_bias(0, 32'd0);
        a_set_bias(1, 32'd0);
        tick();
        begin
            int           sent = 0;
            int           got  = 0;
            int           occ  = 0;
            logic         prev_stall = 1'b0;
            logic [127:0] prev_data  = '0;
            logic         saw_block  = 1'b0;
            for (int t = 0; t < 40 && got < 6; t++) begin
                a_ready_i = !(t >= 3 && t <= 6);
                a_valid_i = (sent < 6);
                a_data_i  = a_beat(sent + 1);
                #1;
                if (prev_stall) check("t3_hold", a_data_o, prev_data);
                check("t3_ready", a_ready_o, (occ < 2) || a_ready_i);
                if (!a_ready_o) saw_block = 1'b1;
                if (a_valid_o && a_ready_i) begin
                    check("t3_order", a_data_o, a_beat(got + 1));
                    got++;
                    occ--;
                end
                if (a_valid_i && a_ready_o) begin
                    sent++;
                    occ++;
                end
                prev_stall = a_valid_o && !a_ready_i;
                prev_data  = a_data_o;
                tick();
            end
            a_valid_i = 1'b0;
            a_ready_i = 1'b1;
            check("t3_count", got, 6);
            check("t3_blocked", saw_block, 1'b1);
            tick();
            tick();
            check("t3_no_dup", a_valid_o, 1'b0);
        end

        // ---------------- 4: bias write races an accept ----------------
        a_data_i    = {32'd0, 32'd1, 32'd0, 32'd0};
        a_valid_i   = 1'b1;
        a_bias_we   = 1'b1;
        a_bias_sel  = 2'd2;
        a_bias_data = 32'd50;
        #1;
        check("t4_ready", a_ready_o, 1'b1);
        tick();                 // beat A is accepted on the write edge
        a_bias_we = 1'b0;
        tick();                 // beat B is accepted one edge later
        a_valid_i = 1'b0;
        check("t4_a_valid", a_valid_o, 1'b1);
        check("t4_a_data", a_data_o, {32'd0, 32'd1, 32'd0, 32'd0});
        tick();
        check("t4_b_valid", a_valid_o, 1'b1);
        check("t4_b_data", a_data_o, {32'd0, 32'd51, 32'd0, 32'd0});
        tick();

        // ---------------- 5: asynchronous reset mid-stream ----------------
        for (int k = 0; k < 4; k++) a_set_bias(k, 32'(7 + k));
        a_ready_i = 1'b0;
        a_data_i  = {32'd1, 32'd1, 32'd1, 32'h7FFFFFFF};
        a_valid_i = 1'b1;
        tick();
        tick();
        a_valid_i = 1'b0;
        check("t5_pre_valid", a_valid_o, 1'b1);
        check("t5_pre_sat", a_sat_o, 4'b0001);
        check("t5_pre_full", a_ready_o, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("t5_valid", a_valid_o, 1'b0);
        check("t5_data", a_data_o, '0);
        check("t5_sat", a_sat_o, '0);
        tick();
        rst = 1'b0;
        check("t5_hold_valid", a_valid_o, 1'b0);
        a_ready_i = 1'b1;
        a_data_i  = {32'd5, 32'd5, 32'd5, 32'd5};
        a_valid_i = 1'b1;
        tick();
        a_valid_i = 1'b0;
        tick();
        check("t5_new_valid", a_valid_o, 1'b1);
        check("t5_new_data", a_data_o, {32'd5, 32'd5, 32'd5, 32'd5});
        check("t5_new_sat", a_sat_o, 4'b0000);

        // ---------------- 6: random regression on instance B ----------------
        begin
            longint mb [8];
            exp_t   q [$];
            int     retired = 0;
            int     cycles  = 0;
            logic   holding = 1'b0;
            for (int k = 0; k < 8; k++) mb[k] = 0;
            while (retired < 10000 && cycles < 60000) begin
                if (!holding && $urandom_range(0, 3) != 0) begin
                    for (int k = 0; k < 8; k++) b_data_i[k*32 +: 32] = rnd_val();
                    holding = 1'b1;
                end
                b_valid_i   = holding;
                b_ready_i   = ($urandom_range(0, 3) != 0);
                b_bias_we   = ($urandom_range(0, 9) == 0);
                b_bias_sel  = 3'($urandom_range(0, 7));
                b_bias_data = rnd_val();
                #1;
                check("b_valid", b_valid_o, (q.size() > 0) && (cycles - q[0].acc >= 2));
                check("b_ready", b_ready_o, (q.size() < 2) || b_ready_i);
                if (b_valid_o && b_ready_i) begin
                    if (q.size() > 0) begin
                        check("b_data", b_data_o, q[0].d);
                        check("b_sat", b_sat_o, q[0].s);
                        void'(q.pop_front());
                    end
                    retired++;
                end
                if (b_valid_i && b_ready_o) begin
                    exp_t e;
                    e.d   = '0;
                    e.s   = '0;
                    e.acc = cycles;
                    for (int k = 0; k < 8; k++) begin
                        longint sum;
                        sum = longint'($signed(b_data_i[k*32 +: 32])) + mb[k];
                        if (sum > 32767) begin
                            e.d[k*16 +: 16] = 16'h7FFF;
                            e.s[k] = 1'b1;
                        end else if (sum < -32768) begin
                            e.d[k*16 +: 16] = 16'h8000;
                            e.s[k] = 1'b1;
                        end else begin
                            e.d[k*16 +: 16] = 16'(sum);
                        end
                    end
                    q.push_back(e);
                    holding = 1'b0;
                end
                // The bias update lands after the accept, so a same-cycle beat
                // uses the old value.
                if (b_bias_we) mb[b_bias_sel] = longint'($signed(b_bias_data));
                tick();
                cycles++;
            end
            b_valid_i = 1'b0;
            b_bias_we = 1'b0;
            check("b_done", retired, 10000);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
